// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Owns the single instruction-memory port. A boot loader writes program
//   words through it while boot_en is high; otherwise the fetch path reads
//   from it, registering each word into the IF/ID stage with a valid flag.
//   Also handles stall, branch/jump redirect and misaligned-target traps.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   boot_en                  1 = loader owns IMEM, fetch halted
//   ld_valid/ld_addr/ld_data loader write request, byte address, data word
//   ld_ready                 loader port accepting (LOAD only)
//   ld_count                 accepted loader writes since LOAD entry
//   mem_addr/mem_we/mem_wdata/mem_rdata   IMEM port (rdata combinational)
//   stall, redirect, redirect_pc, trap_clr   pipeline control
//   if_pc/if_inst/if_valid   registered fetch stage
//   misalign/trap_pc         trap indication and offending target
//
// state | meaning
// IDLE  | one cycle after reset, choose LOAD or RUN
// LOAD  | loader owns IMEM, fetch halted
// RUN   | fetching one word per cycle from pc
// TRAP  | misaligned redirect seen, waiting for trap_clr or boot_en
module imem_fetch_ctrl #(
  parameter int INST_W = 32,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_en,
  input  logic              ld_valid,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [INST_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [CNT_W-1:0]  ld_count,
  output logic [PC_W-1:0]   mem_addr,
  output logic              mem_we,
  output logic [INST_W-1:0] mem_wdata,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              trap_clr,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid,
  output logic              misalign,
  output logic [PC_W-1:0]   trap_pc
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, TRAP} state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc, pc_nx;
  logic [PC_W-1:0]   if_pc_nx;
  logic [INST_W-1:0] if_inst_nx;
  logic              if_valid_nx;
  logic              misalign_nx;
  logic [PC_W-1:0]   trap_pc_nx;
  logic [CNT_W-1:0]  ld_count_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
      misalign <= 1'b0;
      trap_pc  <= '0;
      ld_count <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      if_pc    <= if_pc_nx;
      if_inst  <= if_inst_nx;
      if_valid <= if_valid_nx;
      misalign <= misalign_nx;
      trap_pc  <= trap_pc_nx;
      ld_count <= ld_count_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    if_pc_nx    = if_pc;
    if_inst_nx  = if_inst;
    if_valid_nx = if_valid;
    misalign_nx = misalign;
    trap_pc_nx  = trap_pc;
    ld_count_nx = ld_count;
    ld_ready    = 1'b0;
    mem_addr    = pc;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    case (state)
      IDLE: begin
        if (boot_en) begin
          state_nx    = LOAD;
          ld_count_nx = '0;
        end else begin
          state_nx = RUN;
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        // Word-misaligned loader writes are silently dropped.
        mem_we    = ld_valid && (ld_addr[1:0] == 2'b00);
        if (mem_we) ld_count_nx = ld_count + CNT_W'(1);
        if (!boot_en) begin
          state_nx    = RUN;
          pc_nx       = RESET_PC;
          if_valid_nx = 1'b0;
        end
      end
      RUN: begin
        if (boot_en) begin
          state_nx    = LOAD;
          if_valid_nx = 1'b0;
          ld_count_nx = '0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
          state_nx    = TRAP;
          misalign_nx = 1'b1;
          trap_pc_nx  = redirect_pc;
          if_valid_nx = 1'b0;
        end else if (redirect) begin
          // Redirect beats stall; the word already on the port is flushed.
          pc_nx       = redirect_pc;
          if_valid_nx = 1'b0;
        end else if (!stall) begin
          if_inst_nx  = mem_rdata;
          if_pc_nx    = pc;
          if_valid_nx = 1'b1;
          pc_nx       = pc + PC_W'(4);
        end
      end
      TRAP: begin
        if_valid_nx = 1'b0;
        if (boot_en) begin
          state_nx    = LOAD;
          misalign_nx = 1'b0;
          ld_count_nx = '0;
        end else if (trap_clr) begin
          state_nx    = RUN;
          pc_nx       = RESET_PC;
          misalign_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, boot_en, ld_valid, stall, redirect, trap_clr;
  logic [31:0] ld_addr, ld_data, redirect_pc, mem_rdata;
  logic        ld_ready, mem_we, if_valid, misalign;
  logic [17:0] ld_count;
  logic [31:0] mem_addr, mem_wdata, if_pc, if_inst, trap_pc;

  logic [31:0] mem [64];
  int n_vec = 0;
  int n_err = 0;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .boot_en(boot_en), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_count(ld_count), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .trap_clr(trap_clr),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .misalign(misalign), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'hDEAD_0000;
    mem[1] = 32'hDEAD_0001;
    rst = 1'b1; boot_en = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; trap_clr = 1'b0;
    #3;
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_trap_pc", trap_pc, 0);
    chk("rst_ld_count", ld_count, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ld_ready", ld_ready, 0);

    step(); rst = 1'b0;
    step();                                   // IDLE -> LOAD
    chk("load_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h13; #1;
    chk("load_we0", mem_we, 1);
    chk("load_addr0", mem_addr, 32'h0);
    chk("load_wdata0", mem_wdata, 32'h13);
    step();
    chk("load_cnt1", ld_count, 1);
    ld_addr = 32'h4; #1;
    chk("load_we1", mem_we, 1);
    step();
    ld_addr = 32'h6; ld_data = 32'h0000_0BAD; #1;
    chk("load_we_misaligned", mem_we, 0);
    step();
    chk("load_cnt2", ld_count, 2);
    ld_valid = 1'b0; boot_en = 1'b0;
    step();                                   // LOAD -> RUN
    chk("run_entry_valid", if_valid, 0);
    chk("run_entry_ld_ready", ld_ready, 0);
    chk("run_entry_mem_addr", mem_addr, 32'h0);
    chk("run_entry_wdata", mem_wdata, 32'h0);
    chk("run_cnt_hold", ld_count, 2);
    step();
    chk("f0_pc", if_pc, 32'h0);
    chk("f0_inst", if_inst, 32'h13);
    chk("f0_valid", if_valid, 1);
    step();
    chk("f1_pc", if_pc, 32'h4);
    chk("f1_inst", if_inst, 32'h13);
    step();
    chk("f2_pc", if_pc, 32'h8);
    chk("f2_inst", if_inst, 32'hA000_0002);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_inst", if_inst, 32'hA000_0002);
      chk("stall_valid", if_valid, 1);
    end
    stall = 1'b0;
    step();
    chk("f3_pc", if_pc, 32'hC);
    chk("f3_inst", if_inst, 32'hA000_0003);

    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk("redir_flush", if_valid, 0);
    chk("redir_mem_addr", mem_addr, 32'h40);
    stall = 1'b0; redirect = 1'b0;
    step();
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_inst", if_inst, 32'hA000_0010);
    chk("redir_valid", if_valid, 1);

    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    chk("trap_misalign", misalign, 1);
    chk("trap_pc", trap_pc, 32'h42);
    chk("trap_valid", if_valid, 0);
    for (int i = 0; i < 5; i++) begin
      redirect = i[0]; stall = ~i[0]; redirect_pc = 32'h80;
      step();
      chk("trap_hold_misalign", misalign, 1);
      chk("trap_hold_pc", trap_pc, 32'h42);
      chk("trap_hold_valid", if_valid, 0);
      chk("trap_hold_if_pc", if_pc, 32'h40);
    end
    redirect = 1'b0; stall = 1'b0; trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("clr_misalign", misalign, 0);
    chk("clr_mem_addr", mem_addr, 32'h0);
    step();
    chk("clr_if_pc", if_pc, 32'h0);
    chk("clr_if_valid", if_valid, 1);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_inst", if_inst, 32'hA000_003F);
    chk("wrap_mem_addr", mem_addr, 32'h0);

    boot_en = 1'b1;
    step();                                   // RUN -> LOAD
    chk("reload_cnt_clr", ld_count, 0);
    chk("reload_valid", if_valid, 0);
    chk("reload_ready", ld_ready, 1);
    ld_valid = 1'b1; ld_addr = 32'h8; ld_data = 32'h55;
    step();
    chk("reload_cnt1", ld_count, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_we", mem_we, 0);
    chk("arst_ld_ready", ld_ready, 0);
    chk("arst_ld_count", ld_count, 0);
    chk("arst_if_pc", if_pc, 0);
    chk("arst_if_inst", if_inst, 0);
    chk("arst_wdata", mem_wdata, 0);
    boot_en = 1'b0; ld_valid = 1'b0;
    step(); rst = 1'b0;
    step();                                   // IDLE -> RUN
    chk("post_rst_valid", if_valid, 0);
    chk("post_rst_ready", ld_ready, 0);
    step();
    chk("post_rst_if_pc", if_pc, 32'h0);
    chk("post_rst_if_valid", if_valid, 1);
    chk("post_rst_if_inst", if_inst, 32'h13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Sequencer and port owner for the instruction memory. It shares the single IMEM port between a boot loader that writes program words and the fetch path that reads them. It holds the program counter and registers each fetched word into the IF/ID stage with a valid flag. It also handles pipeline stall, branch/jump redirect and misaligned-target traps.

Parameters:
INST_W, 32, instruction/data word width
PC_W, 32, program counter and memory address width
RESET_PC, 32'h0000_0000, fetch start address after reset, load or trap clear (word aligned)
CNT_W, 18, width of the loader word counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
boot_en  in  1  level; 1 = loader owns IMEM, fetch halted
ld_valid  in  1  loader write request
ld_addr  in  PC_W  loader byte address
ld_data  in  INST_W  loader write word
ld_ready  out  1  loader port accepting (combinational, =1 only in LOAD)
ld_count  out  CNT_W  number of accepted loader writes since entering LOAD
mem_addr  out  PC_W  IMEM byte address (combinational from state)
mem_we  out  1  IMEM write enable
mem_wdata  out  INST_W  IMEM write data
mem_rdata  in  INST_W  IMEM read data, combinational on mem_addr
stall  in  1  hold fetch stage
redirect  in  1  load new PC (branch/jump taken)
redirect_pc  in  PC_W  redirect target
trap_clr  in  1  leave TRAP
if_pc  out  PC_W  PC of registered instruction
if_inst  out  INST_W  registered instruction
if_valid  out  1  if_inst/if_pc valid
misalign  out  1  high while in TRAP
trap_pc  out  PC_W  offending redirect target

Behaviour:
- Reset, asynchronous: state=IDLE, pc=RESET_PC. if_pc, if_inst, if_valid, misalign, trap_pc and ld_count are all 0.
- IDLE: mem_we=0, mem_addr=pc. Next state is LOAD if boot_en=1, else RUN. Spends exactly one cycle.
- LOAD: ld_ready=1, mem_addr=ld_addr, mem_wdata=ld_data.
  - mem_we = ld_valid & (ld_addr[1:0]==0). Misaligned writes are dropped and not counted.
  - Each accepted write increments ld_count, wrapping mod 2^CNT_W.
  - When boot_en=0: go to RUN, pc=RESET_PC, if_valid=0. ld_count holds its value until the next LOAD entry, which clears it.
- RUN: mem_we=0, mem_addr=pc. Per-edge priority:
  1. boot_en=1: go to LOAD, if_valid<=0, ld_count<=0.
  2. redirect=1 with redirect_pc[1:0]!=0: go to TRAP, misalign<=1, trap_pc<=redirect_pc, if_valid<=0, pc unchanged.
  3. redirect=1, aligned target: pc<=redirect_pc, if_valid<=0 (one-cycle flush). Redirect wins over stall.
  4. stall=1: pc, if_pc, if_inst and if_valid all hold.
  5. Otherwise: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^PC_W, so 32'hFFFF_FFFC wraps to 0).
- Fetch latency: the word at pc appears on if_inst one edge after pc is presented on mem_addr. Unstalled throughput is 1 instruction/cycle.
- TRAP: mem_we=0, if_valid=0, misalign=1, trap_pc held.
  - boot_en=1 goes to LOAD (misalign<=0). This has priority over trap_clr.
  - trap_clr=1 goes to RUN with pc=RESET_PC and misalign<=0.
  - stall and redirect are ignored.
- rst asserted in any state, including mid-LOAD with ld_valid high, forces the reset values immediately. An in-flight write is abandoned because mem_we drops combinationally.
- mem_wdata=0 outside LOAD.

Test Plan:
- Reset, boot_en=1, write 0x13 to addrs 0x0 and 0x4, then ld_addr 0x6 with ld_valid -> mem_we pulses only for the first two writes, ld_count=2. Drop boot_en -> RUN, if_pc=0x0 then 0x4, if_inst matches loaded words.
- Free-run with no stall from RESET_PC=0 -> if_pc sequence 0,4,8,C on consecutive cycles, if_valid=1 from the second cycle after RUN entry.
- Stall for 3 cycles at if_pc=0x8 -> if_pc/if_inst/if_valid unchanged for 3 cycles, then 0xC follows.
- redirect with redirect_pc=0x40 while stall=1 -> next cycle if_valid=0, following cycle if_pc=0x40, if_valid=1.
- redirect_pc=0x42 -> misalign=1, trap_pc=0x42, if_valid=0. Hold for 5 cycles with redirect toggling (no change), then trap_clr -> RUN, first if_pc=RESET_PC.
- Assert rst mid-LOAD with ld_valid=1 -> mem_we=0 and all outputs 0 immediately, without waiting for a clock edge. Release -> IDLE, then RUN (boot_en=0).
